// File: rtl/vga_frame_writer_pkg.sv
// Shared sizes, writer state type and the magnitude-to-height scaling helper
// for the VGA frame writer and its ping-pong bank.
package vga_pkg;

  localparam int N_BINS   = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 16;
  localparam int HEIGHT_W = 10;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_e;

  // Shift the raw magnitude down, then clamp to the bar-height ceiling.
  function automatic logic [HEIGHT_W-1:0] scale_sat(
    input logic [DATA_W-1:0] mag,
    input int                shift,
    input int                max_h
  );
    logic [DATA_W-1:0] h;
    h = mag >> shift;
    if (32'(h) > max_h) begin
      return HEIGHT_W'(max_h);
    end
    return h[HEIGHT_W-1:0];
  endfunction

endpackage

// File: rtl/vga_frame_writer_pingpong_bank.sv
// Two 16x16 height banks: one is written while the other is read through two
// independent ports with a registered address and registered data.
module vga_pingpong_bank
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              swap,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] radd_a,
  input  logic [ADDR_W-1:0] radd_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic              rd_sel;
  logic [DATA_W-1:0] mem [2][N_BINS];
  logic [ADDR_W-1:0] radd_a_q;
  logic [ADDR_W-1:0] radd_b_q;

  // The bank not selected for reading is always the write bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_sel <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_BINS; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else begin
      if (swap) begin
        rd_sel <= ~rd_sel;
      end
      if (we) begin
        mem[~rd_sel][waddr] <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      radd_a_q <= '0;
      radd_b_q <= '0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      radd_a_q <= radd_a;
      radd_b_q <= radd_b;
      rdata_a  <= mem[rd_sel][radd_a_q];
      rdata_b  <= mem[rd_sel][radd_b_q];
    end
  end

endmodule

// File: rtl/vga_frame_writer.sv
// Producer side of the VGA bar buffer: scales spectrum bins into heights and
// publishes full frames via display_start_o. Optional peak hold: PEAK_HOLD_EN.
module vga_frame_writer
  import vga_pkg::*;
#(
  parameter int SCALE_SHIFT = 6,
  parameter int MAX_HEIGHT  = 1023,
  parameter int DECAY       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bin_valid_i,
  input  logic [DATA_W-1:0] bin_data_i,
  input  logic              bin_last_i,
  output logic              bin_ready_o,
  input  logic              vga_buff_reading_i,
  input  logic [ADDR_W-1:0] vga_buff_radd_a_i,
  input  logic [ADDR_W-1:0] vga_buff_radd_b_i,
  output logic [DATA_W-1:0] vga_buff_rdata_a_o,
  output logic [DATA_W-1:0] vga_buff_rdata_b_o,
  output logic              display_start_o,
  output logic              frame_err_o
);

  wr_state_e           state, state_next;
  logic [ADDR_W-1:0]   index, index_next;
  logic                ready_q;
  logic                display_start;
  logic                frame_err;
  logic                accept;
  logic                last_idx;
  logic                frame_abort;
  logic                we;
  logic                swap;
  logic [HEIGHT_W-1:0] h_sat;
  logic [HEIGHT_W-1:0] h_store;
  logic [DATA_W-1:0]   wdata;

  assign accept      = bin_valid_i & ready_q;
  assign last_idx    = (index == ADDR_W'(N_BINS - 1));
  assign frame_abort = accept & bin_last_i & ~last_idx;
  assign we          = accept & ~frame_abort;
  assign swap        = (state == FULL) & ~display_start & ~vga_buff_reading_i;
  assign h_sat       = scale_sat(bin_data_i, SCALE_SHIFT, MAX_HEIGHT);

  always_comb begin
    state_next = state;
    index_next = index;
    case (state)
      FILL: begin
        if (accept) begin
          if (frame_abort) begin
            index_next = '0;
          end else if (last_idx) begin
            state_next = FULL;
            index_next = '0;
          end else begin
            index_next = index + 1'b1;
          end
        end
      end
      FULL: begin
        if (swap) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Ready is registered so it stays low through reset; it then tracks FILL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= FILL;
      index         <= '0;
      ready_q       <= 1'b0;
      display_start <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state     <= state_next;
      index     <= index_next;
      ready_q   <= (state_next == FILL);
      frame_err <= frame_abort;
      if (swap) begin
        display_start <= 1'b1;
      end else if (vga_buff_reading_i) begin
        display_start <= 1'b0;
      end
    end
  end

`ifdef PEAK_HOLD_EN
  logic [HEIGHT_W-1:0] peak [N_BINS];
  logic [HEIGHT_W-1:0] peak_dec;

  assign peak_dec = (peak[index] > HEIGHT_W'(DECAY)) ? (peak[index] - HEIGHT_W'(DECAY)) : '0;
  assign h_store  = (h_sat > peak_dec) ? h_sat : peak_dec;

  // Peaks follow every real write, including ones later lost to a framing error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BINS; i++) begin
        peak[i] <= '0;
      end
    end else if (we) begin
      peak[index] <= h_store;
    end
  end
`else
  assign h_store = h_sat;
`endif

  assign wdata = {{(DATA_W - HEIGHT_W){1'b0}}, h_store};

  vga_pingpong_bank u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .swap    (swap),
    .we      (we),
    .waddr   (index),
    .wdata   (wdata),
    .radd_a  (vga_buff_radd_a_i),
    .radd_b  (vga_buff_radd_b_i),
    .rdata_a (vga_buff_rdata_a_o),
    .rdata_b (vga_buff_rdata_b_o)
  );

  assign bin_ready_o     = ready_q;
  assign display_start_o = display_start;
  assign frame_err_o     = frame_err;

endmodule

// File: doc/vga_frame_writer.md
Name: vga_frame_writer

Overview:
- Producer side of the 16-sample VGA buffer.
- Accepts a stream of spectrum magnitude bins and scales each to a bar height in 0..1023.
- Stores heights in a ping-pong pair of 16x16 register banks, so a complete frame is always stable for the reader.
- Serves the VGA controller's two read ports, and raises display_start_o / waits for the reading handshake before publishing the next frame.

Parameters:
- SCALE_SHIFT, 6, right-shift applied to the 16-bit magnitude before saturation.
- MAX_HEIGHT, 1023, saturation ceiling for a stored height (fits 10 bits; stored zero-extended to 16).
- DECAY, 8, per-frame peak decay step (used only with PEAK_HOLD_EN).

Ports:
- clk  in  1  pixel/system clock
- rst_n  in  1  reset, synchronous, active-low
- bin_valid_i  in  1  magnitude bin valid
- bin_data_i  in  16  unsigned magnitude
- bin_last_i  in  1  marks final bin of a frame
- bin_ready_o  out  1  writer can accept a bin
- vga_buff_reading_i  in  1  reader busy copying (acknowledges display_start_o)
- vga_buff_radd_a_i  in  4  read address, port A
- vga_buff_radd_b_i  in  4  read address, port B
- vga_buff_rdata_a_o  out  16  height at radd_a, 2-cycle latency
- vga_buff_rdata_b_o  out  16  height at radd_b, 2-cycle latency
- display_start_o  out  1  new frame published, held until acknowledged
- frame_err_o  out  1  one-cycle pulse on framing error

Behaviour:
- Reset is synchronous on rst_n low at the clk edge; clk/rst_n are the only clock/reset.
- Reset values:
  - bin_ready_o=0, display_start_o=0, frame_err_o=0, rdata_a/b=0.
  - Both banks and all peak registers=0; read bank=0, write bank=1; bin index=0; state=FILL.
- Reset mid-operation discards the partial frame and any pending start.
- Scaling: h = bin_data_i >> SCALE_SHIFT. If h > MAX_HEIGHT, store MAX_HEIGHT; otherwise store h. The stored word has bits [15:10]=0.
- State FILL:
  - bin_ready_o=1.
  - On each accept (valid & ready), write scaled h to write_bank[index], then index+1.
  - Accept with index==15 → state FULL, index←0. bin_last_i is not required at index 15.
  - Accept with bin_last_i=1 and index!=15 → write suppressed, frame_err_o pulses next cycle, index←0, remain FILL, no publish.
- State FULL:
  - bin_ready_o=0.
  - Swap when display_start_o==0 and vga_buff_reading_i==0. On that edge: toggle read/write bank, display_start_o←1, state←FILL.
  - Minimum latency: display_start_o is high after the 2nd rising edge following the index-15 accept.
- Handshake:
  - display_start_o clears on the first edge where vga_buff_reading_i is sampled 1.
  - While display_start_o=1 or reading_i=1, no swap occurs. The writer stalls in FULL (lossless back-pressure, no frame drop).
- Read path:
  - Edge 1 registers the address; edge 2 registers data from the read bank, i.e. data valid 2 cycles after the address is presented.
  - Both ports are independent; equal addresses are legal.
  - The read bank never changes while reading_i=1.
- Simultaneous events:
  - Swap and ack cannot coincide, since swap requires display_start_o=0.
  - A framing error in FILL does not affect the read bank or pending start.

Optional Feature:
- Macro PEAK_HOLD_EN.
- Defined:
  - Per-bin 10-bit peak register.
  - Stored height = max(h_sat, peak − DECAY); subtraction floors at 0.
  - The peak register is updated to the stored value on the same write.
  - Peaks reset to 0.
  - A framing error discards the bins already written in the aborted frame, but their peak updates stand.
- Not defined: the stored height is h_sat directly and no peak registers exist.

Decomposition:
- Package vga_pkg holds:
  - N_BINS=16, ADDR_W=4, DATA_W=16, HEIGHT_W=10.
  - The writer state enum (FILL, FULL).
  - The scale/saturate function.
- One natural sub-module: vga_pingpong_bank.
  - Two 16x16 banks, one write port, two registered read ports.
  - Contains the bank-select flop.

Test Plan:
- After reset, stream bin k = k*64 for k=0..15 (SHIFT=6), reading_i=0 → display_start_o=1 two edges after bin 15 accept; radd_a=3 → rdata_a=16'd3 two cycles later; radd_b=15 → 16'd15.
- bin_data_i=16'hFFFF at index 7 → stored 16'd1023. bin_data_i=16'd63 → stored 0.
- Hold reading_i=0 with display_start_o=1 and stream a second full frame → bin_ready_o=0 after its bin 15, no swap, no bins lost. Then pulse reading_i high for 9 cycles, then low → display_start_o clears on the ack edge; the second frame publishes one cycle after reading_i returns low.
- Frame completes while reading_i=1 → rdata for all 16 addresses stays at the old frame until reading_i falls.
- bin_last_i=1 at index 5 → frame_err_o pulses once, display_start_o stays 0, the next accepted bin lands at index 0.
- PEAK_HOLD_EN, DECAY=8: bin 2 height 500, then next frame height 0 → stored 492, then 484. Without the macro → 0.
